// File: rtl/riscv_if_if.sv
// Instruction-memory bus between fetch (master) and imem (slave).
// Request: valid/ready/addr. Response: valid/data, in order, no backpressure.
interface riscv_if_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/riscv_if.sv
// Fetch stage: PC, imem requests, response FIFO, redirect flush.
// Ports: clk, rst_n, fetch_en, imem (master), redirect_valid/pc,
//   id_ready, if_valid/pc/instr to decode, perf_fetch_cnt.
// Optional macro RISCV_IF_PERF_CNT_EN builds the delivered-instr counter.
module riscv_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  riscv_if_if.master  imem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] perf_fetch_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_sq_wr;
  logic [AW-1:0]   r_sq_rd;
  logic [31:0]     r_fpc  [FIFO_DEPTH];
  logic [31:0]     r_fins [FIFO_DEPTH];
  logic [31:0]     r_spc  [FIFO_DEPTH];

  logic            w_pop;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_req;
  logic            w_xfer;
  logic [CW-1:0]   w_occ_eff;
  logic [CW:0]     w_load;
  logic [31:0]     w_tgt;

  assign if_valid  = (r_occ != '0);
  assign w_pop     = if_valid && id_ready;
  assign w_rsp     = imem.imem_rsp_valid;
  assign w_drop    = (r_drop != '0);
  assign w_push    = w_rsp && !w_drop && !redirect_valid;
  assign w_tgt     = redirect_pc & ~32'h3;

  // A same-cycle pop frees its slot, which keeps
  // single-cycle memory at one instruction per cycle
  // while still never landing a response on a full FIFO.
  assign w_occ_eff = r_occ - CW'(w_pop);
  assign w_load    = {1'b0, w_occ_eff} + {1'b0, r_outst};
  assign w_req     = (r_state == RUN) && (w_load < DEPTH_W)
                     && !redirect_valid;
  assign w_xfer    = w_req && imem.imem_req_ready;

  assign imem.imem_req_valid = w_req;
  assign imem.imem_req_addr  = r_fetch_pc;

  assign if_pc    = if_valid ? r_fpc[r_rd]  : 32'h0;
  assign if_instr = if_valid ? r_fins[r_rd] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (fetch_en)  r_state <= RUN;
        RUN:  if (!fetch_en) r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_tgt;
    end else if (w_xfer) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Outstanding count and PC shadow run independent of
  // redirects: dropped responses still consume their slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
      r_sq_wr <= '0;
      r_sq_rd <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_xfer) - CW'(w_rsp);
      if (w_xfer) r_sq_wr <= r_sq_wr + AW'(1);
      if (w_rsp)  r_sq_rd <= r_sq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) r_spc[r_sq_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fpc[r_wr]  <= r_spc[r_sq_rd];
      r_fins[r_wr] <= imem.imem_rsp_data;
    end
  end

  // On redirect every in-flight response is stale; one
  // arriving right now is discarded by the flush itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (redirect_valid) begin
      if (w_rsp && r_outst != '0)
        r_drop <= r_outst - CW'(1);
      else
        r_drop <= r_outst;
    end else if (w_rsp && w_drop) begin
      r_drop <= r_drop - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else if (redirect_valid) begin
      r_occ <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
    end
  end

`ifdef RISCV_IF_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perf <= 32'h0;
    else if (w_pop) r_perf <= r_perf + 32'd1;
  end

  assign perf_fetch_cnt = r_perf;
`else
  assign perf_fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_if.sv
// Directed bench for riscv_if with a 1..3 cycle latency imem model.
// Instruction word for address a is 32'h00500093 + a.
module tb_riscv_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] perf_fetch_cnt;

  logic [1:0]  lat = 2'd1;
  logic        p1_v, p2_v, p3_v;
  logic [31:0] p1_d, p2_d, p3_d;
  logic [31:0] e_pc;
  int          n_tests = 0;
  int          n_fail = 0;

  riscv_if_if bus ();

  riscv_if #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .perf_fetch_cnt (perf_fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'h00500093 + a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p3_v <= 1'b0;
      p1_d <= 32'h0; p2_d <= 32'h0; p3_d <= 32'h0;
    end else begin
      p1_v <= bus.imem_req_valid && bus.imem_req_ready;
      p1_d <= f(bus.imem_req_addr);
      p2_v <= p1_v; p2_d <= p1_d;
      p3_v <= p2_v; p3_d <= p2_d;
    end
  end

  assign bus.imem_req_ready = 1'b1;
  assign bus.imem_rsp_valid = (lat == 2'd1) ? p1_v :
                              (lat == 2'd2) ? p2_v : p3_v;
  assign bus.imem_rsp_data  = (lat == 2'd1) ? p1_d :
                              (lat == 2'd2) ? p2_d : p3_d;

  always @(negedge clk) begin
    if (rst_n && bus.imem_rsp_valid && dut.r_occ == 2'd2) begin
      n_fail++;
      $display("FAIL rsp_into_full_fifo occ=%0d", dut.r_occ);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_if_valid got %0b want 0", if_valid); end
    n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_req_valid got %0b want 0", bus.imem_req_valid); end
    n_tests++; if (bus.imem_req_addr !== 32'h0) begin n_fail++;
      $display("FAIL rst_req_addr got %h want 0", bus.imem_req_addr); end
    n_tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_fail++;
      $display("FAIL rst_if_pc_instr got %h %h want 0 0", if_pc, if_instr); end
    n_tests++; if (perf_fetch_cnt !== 32'h0) begin n_fail++;
      $display("FAIL rst_perf got %0d want 0", perf_fetch_cnt); end
  endtask

  task automatic test_fetch();
    rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1; lat = 2'd1;
    @(negedge clk);
    n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL fetch_first_req got v=%0b a=%h want 1 0",
        bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk);
    n_tests++; if (bus.imem_req_addr !== 32'h4 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_second_req got a=%h v=%0b want 4 0",
        bus.imem_req_addr, if_valid); end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 ||
                   if_instr !== 32'h00500093) begin
      n_fail++; $display("FAIL fetch_first_instr got v=%0b pc=%h i=%h want 1 0 00500093",
        if_valid, if_pc, if_instr); end
    n_tests++; if (bus.imem_req_addr !== 32'h8) begin n_fail++;
      $display("FAIL fetch_third_req got %h want 8", bus.imem_req_addr); end
    e_pc = 32'h4;
    repeat (4) begin
      @(negedge clk);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== e_pc || if_instr !== f(e_pc)) begin
        n_fail++; $display("FAIL fetch_stream got v=%0b pc=%h i=%h want 1 %h %h",
          if_valid, if_pc, if_instr, e_pc, f(e_pc)); end
      e_pc += 32'h4;
    end
    e_pc -= 32'h4;
  endtask

  task automatic test_stall();
    logic [31:0] p;
    p = e_pc;
    id_ready = 1'b0;
    #1;
    n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_req_drop got %0b want 0", bus.imem_req_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== p || if_instr !== f(p) ||
                     bus.imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold got v=%0b pc=%h i=%h rv=%0b want 1 %h %h 0",
          if_valid, if_pc, if_instr, bus.imem_req_valid, p, f(p)); end
    end
    id_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== p + 32'(4*i)) begin
        n_fail++; $display("FAIL stall_release got v=%0b pc=%h want 1 %h",
          if_valid, if_pc, p + 32'(4*i)); end
    end
  endtask

  task automatic drain();
    fetch_en = 1'b0; id_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_tests++; if (if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain got v=%0b rv=%0b want 0 0",
        if_valid, bus.imem_req_valid); end
  endtask

  task automatic test_redirect();
    bit found;
    lat = 2'd3; fetch_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (bus.imem_req_valid !== 1'b1) begin n_fail++;
      $display("FAIL redir_second_req got %0b want 1", bus.imem_req_valid); end
    @(negedge clk);
    n_tests++; if (bus.imem_req_valid !== 1'b0 || bus.imem_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_two_outstanding got rv=%0b rsp=%0b want 0 0",
        bus.imem_req_valid, bus.imem_rsp_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || bus.imem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_t1 got v=%0b a=%h want 0 100",
        if_valid, bus.imem_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (if_valid) begin
        found = 1'b1;
        n_tests++; if (if_pc !== 32'h100 || if_instr !== f(32'h100)) begin
          n_fail++; $display("FAIL redir_target got pc=%h i=%h want 100 %h",
            if_pc, if_instr, f(32'h100)); end
      end
    end
    if (!found) begin n_tests++; n_fail++;
      $display("FAIL redir_timeout got no if_valid want pc 100"); end
  endtask

  task automatic test_redirect_rsp_pop();
    lat = 2'd1; fetch_en = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 10 && !if_valid; i++) @(negedge clk);
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b1 || bus.imem_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rrp_setup got v=%0b rsp=%0b want 1 1",
        if_valid, bus.imem_rsp_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b0 || bus.imem_req_addr !== 32'h200 ||
                   bus.imem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL rrp_t1 got v=%0b a=%h rv=%0b want 0 200 1",
        if_valid, bus.imem_req_addr, bus.imem_req_valid); end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++;
      $display("FAIL rrp_t2 got v=%0b want 0", if_valid); end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== f(32'h200)) begin
      n_fail++; $display("FAIL rrp_t3 got v=%0b pc=%h i=%h want 1 200 %h",
        if_valid, if_pc, if_instr, f(32'h200)); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++; if (bus.imem_req_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_t1 got a=%h v=%0b want fffffffc 0",
        bus.imem_req_addr, if_valid); end
    @(negedge clk);
    n_tests++; if (bus.imem_req_addr !== 32'h0) begin n_fail++;
      $display("FAIL wrap_addr got %h want 0", bus.imem_req_addr); end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC ||
                   if_instr !== f(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_pc_last got v=%0b pc=%h want 1 fffffffc",
        if_valid, if_pc); end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h00500093) begin
      n_fail++; $display("FAIL wrap_pc_zero got v=%0b pc=%h i=%h want 1 0 00500093",
        if_valid, if_pc, if_instr); end
  endtask

  task automatic test_reset_midop();
    rst_n = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 ||
                   bus.imem_req_addr !== 32'h0 || perf_fetch_cnt !== 32'h0) begin
      n_fail++; $display("FAIL midrst got v=%0b rv=%0b a=%h perf=%0d want 0 0 0 0",
        if_valid, bus.imem_req_valid, bus.imem_req_addr, perf_fetch_cnt); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b0;
  endtask

  task automatic test_perf();
    int popped;
    logic [31:0] exp_perf;
`ifdef RISCV_IF_PERF_CNT_EN
    exp_perf = 32'd10;
`else
    exp_perf = 32'd0;
`endif
    popped = 0;
    for (int i = 0; i < 40 && popped < 10; i++) begin
      @(negedge clk);
      if (if_valid) begin
        n_tests++; if (if_pc !== 32'(popped*4)) begin n_fail++;
          $display("FAIL perf_order got pc=%h want %h", if_pc, 32'(popped*4)); end
        id_ready = 1'b1;
        popped++;
      end else begin
        id_ready = 1'b0;
      end
    end
    @(negedge clk);
    id_ready = 1'b0;
    n_tests++; if (popped != 10) begin n_fail++;
      $display("FAIL perf_timeout got %0d pops want 10", popped); end
    n_tests++; if (perf_fetch_cnt !== exp_perf) begin n_fail++;
      $display("FAIL perf_cnt got %0d want %0d", perf_fetch_cnt, exp_perf); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    drain();
    test_redirect();
    drain();
    test_redirect_rsp_pop();
    test_wrap();
    test_reset_midop();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_if.md
# riscv_if

Instruction fetch stage of the ultra-lightweight RISC-V core. It keeps the fetch PC and issues word requests to instruction memory over a valid/ready handshake. In-order responses are buffered in a small FIFO, and the stage presents `if_pc`/`if_instr`/`if_valid` to the decode stage `riscv_id`. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, instruction buffer entries (power of two, ≥2)
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `fetch_en`  in  1  high allows new imem requests
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response valid (in order, no backpressure)
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  taken branch/jump from execute
- `redirect_pc`  in  32  new fetch target
- `id_ready`  in  1  decode consumes head entry
- `if_valid`  out  1  head entry valid
- `if_pc`  out  32  PC of head instruction
- `if_instr`  out  32  head instruction word
- `perf_fetch_cnt`  out  32  delivered-instruction counter (see Configuration)

## Operation
- FSM with two states.
  - IDLE: no requests. Enter it on reset or when `fetch_en`=0.
  - RUN: the stage issues requests. IDLE→RUN when `fetch_en`=1. RUN→IDLE when `fetch_en`=0; in-flight responses still land in the FIFO.
- Issue rule: `imem_req_valid`=1 in RUN when `occupancy + outstanding < FIFO_DEPTH` and no redirect is active this cycle.
- Transfer: one occurs when valid && ready. On transfer, `fetch_pc` += 4, wrapping 32'hFFFF_FFFC→0, and `outstanding` increments.
- Responses:
  - Each `imem_rsp_valid` decrements `outstanding`.
  - If `drop_cnt`>0, the response is discarded and `drop_cnt` decrements.
  - Otherwise `{pc, data}` is pushed. The pc comes from an in-order PC shadow queue of outstanding requests.
- Pop: occurs when `if_valid && id_ready`.
- Redirect (`redirect_valid`=1):
  - FIFO is cleared.
  - `drop_cnt` ← `outstanding`, minus one if a response arrives the same cycle.
  - `fetch_pc` ← `{redirect_pc[31:2], 2'b00}`.
  - A pending request not yet accepted is withdrawn. The memory samples only on valid && ready.
- Simultaneous events:
  - Redirect beats pop, push and issue in the same cycle.
  - Push and pop in the same cycle keep occupancy unchanged.
  - A response can never arrive at a full FIFO; the issue rule guarantees this. The bench asserts it.
- Reset values:
  - All outputs are 0 except `imem_req_addr`, which equals `RESET_PC`.
  - FSM is in IDLE; `fetch_pc`=`RESET_PC`.
  - `occupancy`, `outstanding` and `drop_cnt` are 0.
- Reset mid-operation: all counters and the FIFO are cleared immediately. Any responses that arrive after reset release are ignored only if `drop_cnt`>0. The system must drain memory before releasing `rst_n`.

## Timing
- `imem_req_addr` is registered and equals `fetch_pc`. The request goes out the cycle after entering RUN.
- Response at cycle N gives `if_valid`=1 at N+1, because the FIFO output is registered.
- Back-to-back throughput: 1 instruction/cycle with single-cycle memory.
- Redirect at cycle T:
  - `if_valid`=0 from T+1.
  - `imem_req_addr`=target at T+1.
  - First target instruction reaches `if_valid` at earliest T+3.
- `if_pc`/`if_instr` hold stable while `if_valid`=1 and `id_ready`=0.

## Configuration
- `RISCV_IF_PERF_CNT_EN` defined: `perf_fetch_cnt` increments on every pop. It wraps modulo 2^32, is reset to 0, and is not cleared by redirect.
- Undefined: `perf_fetch_cnt` is tied to 32'h0 and no counter logic is built. The port always exists.

## Test plan
- Reset with `RESET_PC`=0, `fetch_en`=1, 1-cycle memory returning 32'h00500093 at 0 → `imem_req_addr` 0,4,8…; `if_pc`=0, `if_instr`=32'h00500093 two cycles after first request.
- `id_ready`=0 for 5 cycles → at most 2 entries buffered, `imem_req_valid` drops, `if_pc`/`if_instr` stable; releasing gives PCs 0,4 consecutively.
- Redirect to 32'h0000_0103 with 2 requests outstanding → both responses dropped, next `if_pc`=32'h100, FIFO cleared at T+1.
- Redirect in same cycle as `imem_rsp_valid` and pop → response dropped, `drop_cnt` = outstanding−1, no stale `if_valid`.
- Fetch from 32'hFFFF_FFFC → next `imem_req_addr`=0.
- With `RISCV_IF_PERF_CNT_EN`, 10 delivered instructions → `perf_fetch_cnt`=10; without it → 0.
